// File: rtl/ad_conv_sched.sv
// rtl/ad_conv_sched.sv - round-robin scheduler for one shared serial ADC
//
// Purpose: latches per-channel sampling triggers as pending requests, grants
// them round-robin, runs CONVST / wait-BUSY / serial readout on the shared ADC
// and presents a channel-tagged sample on a valid/ready port.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              scheduler enable; low forces IDLE and drops pending
//   ad_start[NCH]       per-channel trigger, rising edge counts
//   adc_convst          ADC conversion start
//   adc_busy            ADC busy flag (clk-synchronous)
//   adc_cs_n, adc_sclk  ADC serial chip select and clock
//   adc_sdo             ADC serial data, MSB first
//   smp_valid/ready     sample handshake
//   smp_data, smp_ch    sample value and channel tag
//   ovf[NCH]            sticky per-channel overrun
//   ovf_clr             one-cycle clear of ovf and timeout_err
//   timeout_err         sticky BUSY timeout
//   sched_busy          FSM not in IDLE
module ad_conv_sched #(
   parameter int NCH      = 4,
   parameter int DATA_W   = 16,
   parameter int CONV_CYC = 4,
   parameter int SCLK_DIV = 2,
   parameter int BUSY_TO  = 1023,
   localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [NCH-1:0]    ad_start,
   output logic              adc_convst,
   input  logic              adc_busy,
   output logic              adc_cs_n,
   output logic              adc_sclk,
   input  logic              adc_sdo,
   output logic              smp_valid,
   input  logic              smp_ready,
   output logic [DATA_W-1:0] smp_data,
   output logic [CH_W-1:0]   smp_ch,
   output logic [NCH-1:0]    ovf,
   input  logic              ovf_clr,
   output logic              timeout_err,
   output logic              sched_busy
);

   localparam int CNT_MAX = (BUSY_TO > CONV_CYC) ? BUSY_TO : CONV_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int DIV_W   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
   localparam int BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_CYC - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(BUSY_TO - 1);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);
   localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NCH - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CONV = 3'd1,
      S_WAIT = 3'd2,
      S_READ = 3'd3,
      S_OUT  = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_next;

   logic [NCH-1:0]      r_ad_start_d;
   logic [NCH-1:0]      r_pending;
   logic [NCH-1:0]      r_ovf;
   logic                r_timeout;
   logic [CH_W-1:0]     r_last_grant;
   logic [CH_W-1:0]     r_ch;
   logic [CNT_W-1:0]    r_cnt;
   logic [DIV_W-1:0]    r_div;
   logic [BIT_W-1:0]    r_bit;
   logic                r_sclk;
   logic [DATA_W-1:0]   r_shift;

   logic [NCH-1:0]      w_edge;
   logic [NCH-1:0]      w_gnt_mask;
   logic [CH_W-1:0]     w_gnt_ch;
   logic                w_gnt_found;
   logic                w_grant;
   logic                w_busy_done;
   logic                w_timeout;
   logic                w_read_done;

   // Edges are ignored while disabled; the delay register keeps tracking so a
   // level held across re-enable does not fake an edge.
   assign w_edge = ad_start & ~r_ad_start_d & {NCH{enable}};

   // Round-robin search: first pass above last_grant, second pass wraps to 0.
   always_comb begin
      w_gnt_found = 1'b0;
      w_gnt_ch    = '0;
      for (int i = 0; i < NCH; i++) begin
         if (!w_gnt_found && r_pending[i] && (i > int'(r_last_grant))) begin
            w_gnt_found = 1'b1;
            w_gnt_ch    = CH_W'(i);
         end
      end
      for (int i = 0; i < NCH; i++) begin
         if (!w_gnt_found && r_pending[i]) begin
            w_gnt_found = 1'b1;
            w_gnt_ch    = CH_W'(i);
         end
      end
   end

   assign w_grant    = (r_state == S_IDLE) && enable && w_gnt_found;
   assign w_gnt_mask = w_grant ? (NCH'(1) << w_gnt_ch) : '0;

   // BUSY is not trusted on the first WAIT cycle (r_cnt == 0); it may still
   // reflect the state before CONVST took effect.
   assign w_busy_done = (r_state == S_WAIT) && (r_cnt != '0) && !adc_busy;
   assign w_timeout   = (r_state == S_WAIT) && enable && !w_busy_done
                        && (r_cnt == TO_LAST);
   // Readout ends at the close of the last high half-period.
   assign w_read_done = (r_state == S_READ) && r_sclk && (r_div == DIV_LAST)
                        && (r_bit == BIT_LAST);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: if (w_grant) w_state_next = S_CONV;
         S_CONV: if (r_cnt == CONV_LAST) w_state_next = S_WAIT;
         S_WAIT: begin
            if (w_busy_done)    w_state_next = S_READ;
            else if (w_timeout) w_state_next = S_IDLE;
         end
         S_READ: if (w_read_done) w_state_next = S_OUT;
         S_OUT:  if (smp_ready) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
      if (!enable) w_state_next = S_IDLE;
   end

   // Output decode
   always_comb begin
      adc_convst = 1'b0;
      adc_cs_n   = 1'b1;
      smp_valid  = 1'b0;
      sched_busy = 1'b0;
      case (r_state)
         S_CONV: begin
            adc_convst = 1'b1;
            sched_busy = 1'b1;
         end
         S_WAIT: sched_busy = 1'b1;
         S_READ: begin
            adc_cs_n   = 1'b0;
            sched_busy = 1'b1;
         end
         S_OUT: begin
            smp_valid  = 1'b1;
            sched_busy = 1'b1;
         end
         default: ;
      endcase
   end

   assign adc_sclk    = r_sclk;
   assign smp_data    = r_shift;
   assign smp_ch      = r_ch;
   assign ovf         = r_ovf;
   assign timeout_err = r_timeout;

   // Request, flag and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ad_start_d <= '0;
         r_pending    <= '0;
         r_ovf        <= '0;
         r_timeout    <= 1'b0;
         r_last_grant <= CH_LAST;
         r_ch         <= '0;
         r_cnt        <= '0;
         r_div        <= '0;
         r_bit        <= '0;
         r_sclk       <= 1'b0;
         r_shift      <= '0;
      end else begin
         r_ad_start_d <= ad_start;

         // A set on the granted channel wins over the grant's clear.
         if (!enable) begin
            r_pending <= '0;
         end else begin
            r_pending <= (r_pending & ~w_gnt_mask) | w_edge;
         end

         // A channel being granted this cycle is entering service, so its
         // new edge is a fresh request rather than an overrun.
         r_ovf     <= (ovf_clr ? '0 : r_ovf) | (w_edge & r_pending & ~w_gnt_mask);
         r_timeout <= (r_timeout & ~ovf_clr) | w_timeout;

         if (w_grant) begin
            r_last_grant <= w_gnt_ch;
            r_ch         <= w_gnt_ch;
         end else if (!enable) begin
            r_ch <= '0;
         end

         // Shared counter: CONVST length in CONV, BUSY timer in WAIT.
         if (((r_state == S_CONV) || (r_state == S_WAIT)) && (w_state_next == r_state)) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end else begin
            r_cnt <= '0;
         end

         if ((r_state == S_READ) && (w_state_next == S_READ)) begin
            if (r_div == DIV_LAST) begin
               r_div  <= '0;
               r_sclk <= ~r_sclk;
               if (r_sclk) begin
                  r_bit <= r_bit + BIT_W'(1);
               end else begin
                  r_shift <= DATA_W'({r_shift, adc_sdo});
               end
            end else begin
               r_div <= r_div + DIV_W'(1);
            end
         end else begin
            r_div  <= '0;
            r_bit  <= '0;
            r_sclk <= 1'b0;
         end

         if (!enable) begin
            r_shift <= '0;
         end
      end
   end

endmodule
